// File: rtl/wb_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wb_arbiter_if : Wishbone B4 classic link (one master, one slave) |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
interface wb_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            cyc;
   logic            stb;
   logic            we;
   logic [AW-1:0]   adr;
   logic [DW-1:0]   dat_w;
   logic [DW/8-1:0] sel;
   logic [DW-1:0]   dat_r;
   logic            ack;
   logic            err;

   modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack, err);
   modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wb_arbiter : two-master / one-slave Wishbone arbiter + watchdog  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module wb_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255,
   parameter int RR      = 0
) (
   input  wire logic    clk_i,
   input  wire logic    rst_i,
   wb_arbiter_if.slave  m0,
   wb_arbiter_if.slave  m1,
   wb_arbiter_if.master s,
   output logic [1:0]   gnt_o
);
   localparam int              c_CW   = $clog2(TIMEOUT + 1);
   localparam logic [c_CW-1:0] c_TMAX = c_CW'(TIMEOUT);
   localparam logic [c_CW-1:0] c_TM1  = c_CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GNT0 = 2'd1,
      S_GNT1 = 2'd2,
      S_TOUT = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic            r_last,  w_last_nxt;
   logic [c_CW-1:0] r_cnt,   w_cnt_nxt;
   logic            w_cur, w_cyc, w_stb;
   logic [AW-1:0]   w_adr;
   logic [DW-1:0]   w_dat;
   logic [DW/8-1:0] w_sel;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_last  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // r_last records the master of the finished tenure; in TOUT it names the erroring master
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      w_cur       = (r_state == S_GNT1);
      w_cyc       = w_cur ? m1.cyc : m0.cyc;
      w_stb       = w_cur ? m1.stb : m0.stb;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (m0.cyc && m1.cyc)
               w_state_nxt = ((RR != 0) && r_last) ? S_GNT0 : S_GNT1;
            else if (m1.cyc)
               w_state_nxt = S_GNT1;
            else if (m0.cyc)
               w_state_nxt = S_GNT0;
         end
         S_GNT0, S_GNT1: begin
            if (s.ack || s.err)
               w_cnt_nxt = '0;
            else if (w_stb && (r_cnt != c_TMAX))
               w_cnt_nxt = r_cnt + 1'b1;
            // a termination in the final watchdog cycle beats the timeout
            if (!w_cyc) begin
               w_state_nxt = S_IDLE;
               w_last_nxt  = w_cur;
            end else if (!(s.ack || s.err) && w_stb && (r_cnt == c_TM1)) begin
               w_state_nxt = S_TOUT;
               w_last_nxt  = w_cur;
            end
         end
         S_TOUT:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_adr = '0;
      w_dat = '0;
      w_sel = '0;
      s.cyc = 1'b0;
      s.stb = 1'b0;
      s.we  = 1'b0;
      m0.ack   = 1'b0;
      m0.err   = 1'b0;
      m0.dat_r = '0;
      m1.ack   = 1'b0;
      m1.err   = 1'b0;
      m1.dat_r = '0;
      gnt_o    = 2'b00;
      case (r_state)
         S_GNT0: begin
            s.cyc = m0.cyc;
            s.stb = m0.stb;
            s.we  = m0.we;
            w_adr = m0.adr;
            w_dat = m0.dat_w;
            w_sel = m0.sel;
            m0.ack   = s.ack;
            m0.err   = s.err;
            m0.dat_r = s.dat_r;
            gnt_o    = 2'b01;
         end
         S_GNT1: begin
            s.cyc = m1.cyc;
            s.stb = m1.stb;
            s.we  = m1.we;
            w_adr = m1.adr;
            w_dat = m1.dat_w;
            w_sel = m1.sel;
            m1.ack   = s.ack;
            m1.err   = s.err;
            m1.dat_r = s.dat_r;
            gnt_o    = 2'b10;
         end
         S_TOUT: begin
            m0.err = ~r_last;
            m1.err = r_last;
            gnt_o  = r_last ? 2'b10 : 2'b01;
         end
         default: ;
      endcase
   end

   assign s.adr   = w_adr;
   assign s.dat_w = w_dat;
   assign s.sel   = w_sel;
endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_wb_arbiter : directed + randomized bench, fixed and RR DUTs   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_wb_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   typedef struct packed {
      logic            s_cyc;
      logic            s_stb;
      logic [AW-1:0]   s_adr;
      logic [DW-1:0]   s_dat;
      logic            s_we;
      logic [DW/8-1:0] s_sel;
      logic            m0_ack;
      logic            m0_err;
      logic [DW-1:0]   m0_dat;
      logic            m1_ack;
      logic            m1_err;
      logic [DW-1:0]   m1_dat;
      logic [1:0]      gnt;
   } obs_t;

   logic clk, rst_n;
   logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack, s_err;
   logic [AW-1:0]   m0_adr, m1_adr;
   logic [DW-1:0]   m0_dat, m1_dat, s_dat;
   logic [DW/8-1:0] m0_sel, m1_sel;
   logic [1:0]      fp_gnt, rr_gnt;
   int n_checks = 0;
   int n_fail   = 0;

   wb_arbiter_if #(.AW(AW), .DW(DW)) fp_m0 (), fp_m1 (), fp_s (), rr_m0 (), rr_m1 (), rr_s ();

   assign fp_m0.cyc = m0_cyc; assign fp_m0.stb = m0_stb; assign fp_m0.we = m0_we;
   assign fp_m0.adr = m0_adr; assign fp_m0.dat_w = m0_dat; assign fp_m0.sel = m0_sel;
   assign fp_m1.cyc = m1_cyc; assign fp_m1.stb = m1_stb; assign fp_m1.we = m1_we;
   assign fp_m1.adr = m1_adr; assign fp_m1.dat_w = m1_dat; assign fp_m1.sel = m1_sel;
   assign rr_m0.cyc = m0_cyc; assign rr_m0.stb = m0_stb; assign rr_m0.we = m0_we;
   assign rr_m0.adr = m0_adr; assign rr_m0.dat_w = m0_dat; assign rr_m0.sel = m0_sel;
   assign rr_m1.cyc = m1_cyc; assign rr_m1.stb = m1_stb; assign rr_m1.we = m1_we;
   assign rr_m1.adr = m1_adr; assign rr_m1.dat_w = m1_dat; assign rr_m1.sel = m1_sel;
   assign fp_s.ack = s_ack; assign fp_s.err = s_err; assign fp_s.dat_r = s_dat;
   assign rr_s.ack = s_ack; assign rr_s.err = s_err; assign rr_s.dat_r = s_dat;

   wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .RR(0)) u_fp (
      .clk_i(clk), .rst_i(rst_n), .m0(fp_m0), .m1(fp_m1), .s(fp_s), .gnt_o(fp_gnt));
   wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .RR(1)) u_rr (
      .clk_i(clk), .rst_i(rst_n), .m0(rr_m0), .m1(rr_m1), .s(rr_s), .gnt_o(rr_gnt));

   obs_t obs [2];
   assign obs[0] = {fp_s.cyc, fp_s.stb, fp_s.adr, fp_s.dat_w, fp_s.we, fp_s.sel,
                    fp_m0.ack, fp_m0.err, fp_m0.dat_r, fp_m1.ack, fp_m1.err, fp_m1.dat_r, fp_gnt};
   assign obs[1] = {rr_s.cyc, rr_s.stb, rr_s.adr, rr_s.dat_w, rr_s.we, rr_s.sel,
                    rr_m0.ack, rr_m0.err, rr_m0.dat_r, rr_m1.ack, rr_m1.err, rr_m1.dat_r, rr_gnt};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic idle_inputs();
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
      s_ack = 0; s_err = 0; s_dat = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1; s_err = 1;
      s_dat = 32'hFFFF_FFFF; m1_adr = 32'h1234_5678;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (obs[0] !== '0) begin n_fail++; $display("FAIL reset_fp_outputs: got %h want 0", obs[0]); end
      n_checks++; if (obs[1] !== '0) begin n_fail++; $display("FAIL reset_rr_outputs: got %h want 0", obs[1]); end
      do_reset();
   endtask

   task automatic test_single_read();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
      #1;
      n_checks++; if (fp_s.cyc !== 1'b0) begin n_fail++; $display("FAIL read_latency_cyc: got %b want 0", fp_s.cyc); end
      @(negedge clk); #1;
      n_checks++; if (fp_s.cyc !== 1'b1) begin n_fail++; $display("FAIL read_s_cyc: got %b want 1", fp_s.cyc); end
      n_checks++; if (fp_s.adr !== 32'h100) begin n_fail++; $display("FAIL read_s_adr: got %h want 100", fp_s.adr); end
      n_checks++; if (fp_gnt !== 2'b01) begin n_fail++; $display("FAIL read_gnt: got %b want 01", fp_gnt); end
      @(negedge clk);
      s_ack = 1; s_dat = 32'hDEADBEEF;
      #1;
      n_checks++; if (fp_m0.ack !== 1'b1) begin n_fail++; $display("FAIL read_m0_ack: got %b want 1", fp_m0.ack); end
      n_checks++; if (fp_m0.dat_r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_m0_dat: got %h want deadbeef", fp_m0.dat_r); end
      n_checks++; if (fp_m1.ack !== 1'b0) begin n_fail++; $display("FAIL read_m1_ack: got %b want 0", fp_m1.ack); end
      @(negedge clk);
      m0_cyc = 0; m0_stb = 0; s_ack = 0;
      @(negedge clk); #1;
      n_checks++; if (fp_gnt !== 2'b00) begin n_fail++; $display("FAIL read_release_gnt: got %b want 00", fp_gnt); end
   endtask

   task automatic test_fixed_priority();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA0; m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB0;
      @(negedge clk);
      s_ack = 1;
      #1;
      n_checks++; if (fp_gnt !== 2'b10) begin n_fail++; $display("FAIL prio_gnt: got %b want 10", fp_gnt); end
      n_checks++; if (fp_s.adr !== 32'hB0) begin n_fail++; $display("FAIL prio_s_adr: got %h want b0", fp_s.adr); end
      n_checks++; if (fp_m1.ack !== 1'b1 || fp_m0.ack !== 1'b0) begin n_fail++; $display("FAIL prio_acks: got m0=%b m1=%b want m0=0 m1=1", fp_m0.ack, fp_m1.ack); end
      @(negedge clk);
      m1_cyc = 0; m1_stb = 0; s_ack = 0;
      @(negedge clk); #1;
      n_checks++; if (fp_gnt !== 2'b00) begin n_fail++; $display("FAIL prio_dead_cycle: got %b want 00", fp_gnt); end
      @(negedge clk); #1;
      n_checks++; if (fp_gnt !== 2'b01) begin n_fail++; $display("FAIL prio_next_gnt: got %b want 01", fp_gnt); end
      idle_inputs();
   endtask

   task automatic test_round_robin();
      int want [4] = '{1, 0, 1, 0};
      do_reset();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      for (int t = 0; t < 4; t++) begin
         int waited = 0;
         @(negedge clk); #1;
         while (rr_gnt == 2'b00 && waited < 6) begin
            @(negedge clk); #1;
            waited++;
         end
         n_checks++;
         if (rr_gnt !== (want[t] == 1 ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL rr_grant_%0d: got %b want master %0d", t, rr_gnt, want[t]);
         end
         s_ack = 1;
         @(negedge clk);
         s_ack = 0;
         if (rr_gnt == 2'b10) m1_cyc = 0; else m0_cyc = 0;
         @(negedge clk);
         m0_cyc = 1; m1_cyc = 1;
      end
      idle_inputs();
   endtask

   task automatic test_timeout(input bit ack_last);
      do_reset();
      m1_cyc = 1; m1_stb = 1;
      for (int i = 1; i <= TO; i++) begin
         @(negedge clk);
         if (ack_last && i == TO) s_ack = 1;
         #1;
         n_checks++; if (fp_m1.err !== 1'b0 || fp_s.cyc !== 1'b1) begin n_fail++; $display("FAIL tout_strobe_%0d: got err=%b cyc=%b want err=0 cyc=1", i, fp_m1.err, fp_s.cyc); end
      end
      if (ack_last) begin
         n_checks++; if (fp_m1.ack !== 1'b1) begin n_fail++; $display("FAIL tout_ack_wins: got ack=%b want 1", fp_m1.ack); end
      end
      @(negedge clk);
      s_ack = 0;
      #1;
      if (ack_last) begin
         n_checks++; if (fp_m1.err !== 1'b0 || fp_gnt !== 2'b10 || fp_s.cyc !== 1'b1) begin n_fail++; $display("FAIL tout_no_tout: got err=%b gnt=%b cyc=%b want 0 10 1", fp_m1.err, fp_gnt, fp_s.cyc); end
      end else begin
         n_checks++; if (fp_m1.err !== 1'b1 || fp_s.cyc !== 1'b0 || fp_m0.err !== 1'b0) begin n_fail++; $display("FAIL tout_err: got m1err=%b cyc=%b m0err=%b want 1 0 0", fp_m1.err, fp_s.cyc, fp_m0.err); end
         @(negedge clk); #1;
         n_checks++; if (fp_m1.err !== 1'b0 || fp_gnt !== 2'b00) begin n_fail++; $display("FAIL tout_idle: got err=%b gnt=%b want 0 00", fp_m1.err, fp_gnt); end
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      do_reset();
      m0_cyc = 1; m0_stb = 1;
      @(negedge clk);
      s_ack = 1;
      #1;
      n_checks++; if (fp_m0.ack !== 1'b1) begin n_fail++; $display("FAIL areset_pre_ack: got %b want 1", fp_m0.ack); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (fp_s.cyc !== 0 || fp_s.stb !== 0 || fp_m0.ack !== 0 || fp_gnt !== 2'b00) begin n_fail++; $display("FAIL areset_immediate: got cyc=%b stb=%b ack=%b gnt=%b want all 0", fp_s.cyc, fp_s.stb, fp_m0.ack, fp_gnt); end
      s_ack = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (fp_gnt !== 2'b01 || fp_s.cyc !== 1'b1) begin n_fail++; $display("FAIL areset_regrant: got gnt=%b cyc=%b want 01 1", fp_gnt, fp_s.cyc); end
      idle_inputs();
   endtask

   // Reference: owner (-1 none), pending-timeout flag, last owner, unterminated strobe count
   task automatic test_random();
      int own [2] = '{-1, -1};
      int lst [2] = '{0, 0};
      int wt  [2] = '{0, 0};
      bit tout[2] = '{0, 0};
      obs_t e, m;
      do_reset();
      for (int cy = 0; cy < 600; cy++) begin
         m0_cyc = m0_cyc ? ($urandom_range(5) != 0) : ($urandom_range(2) == 0);
         m1_cyc = m1_cyc ? ($urandom_range(5) != 0) : ($urandom_range(2) == 0);
         m0_stb = m0_cyc && ($urandom_range(3) != 0);
         m1_stb = m1_cyc && ($urandom_range(3) != 0);
         m0_adr = $urandom; m0_dat = $urandom; m0_we = $urandom_range(1); m0_sel = 4'($urandom);
         m1_adr = $urandom; m1_dat = $urandom; m1_we = $urandom_range(1); m1_sel = 4'($urandom);
         s_ack = ($urandom_range(9) == 0);
         s_err = ($urandom_range(24) == 0);
         s_dat = $urandom;
         #1;
         for (int k = 0; k < 2; k++) begin
            e = '0;
            m = '1;
            if (tout[k]) begin
               if (lst[k] == 1) e.m1_err = 1'b1; else e.m0_err = 1'b1;
               m.s_adr = '0; m.s_dat = '0; m.s_we = 1'b0; m.s_sel = '0; m.gnt = '0;
            end else if (own[k] == 0) begin
               e.s_cyc = m0_cyc; e.s_stb = m0_stb; e.s_adr = m0_adr; e.s_dat = m0_dat;
               e.s_we = m0_we; e.s_sel = m0_sel;
               e.m0_ack = s_ack; e.m0_err = s_err; e.m0_dat = s_dat; e.gnt = 2'b01;
            end else if (own[k] == 1) begin
               e.s_cyc = m1_cyc; e.s_stb = m1_stb; e.s_adr = m1_adr; e.s_dat = m1_dat;
               e.s_we = m1_we; e.s_sel = m1_sel;
               e.m1_ack = s_ack; e.m1_err = s_err; e.m1_dat = s_dat; e.gnt = 2'b10;
            end
            n_checks++;
            if ((obs[k] & m) !== (e & m)) begin
               n_fail++;
               $display("FAIL random_dut%0d_cycle%0d: got %h want %h", k, cy, obs[k] & m, e & m);
            end
            if (tout[k]) begin
               tout[k] = 0; own[k] = -1;
            end else if (own[k] < 0) begin
               if (m0_cyc && m1_cyc) own[k] = (k == 1 && lst[k] == 1) ? 0 : 1;
               else if (m1_cyc) own[k] = 1;
               else if (m0_cyc) own[k] = 0;
               wt[k] = 0;
            end else if (!(own[k] == 1 ? m1_cyc : m0_cyc)) begin
               lst[k] = own[k]; own[k] = -1;
            end else if (s_ack || s_err) begin
               wt[k] = 0;
            end else if (own[k] == 1 ? m1_stb : m0_stb) begin
               wt[k]++;
               if (wt[k] == TO) begin tout[k] = 1; lst[k] = own[k]; end
            end
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      test_reset();
      test_single_read();
      test_fixed_priority();
      test_round_robin();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
